// File: rtl/serial_adder_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl_pkg
// Shared definitions for the bit-serial adder controller:
//   - state_t       : FSM state encoding (IDLE / RUN / DONE)
//   - DEFAULT_WIDTH : default operand/result width
// No ports (package).
// -----------------------------------------------------------------------------
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fulladder.sv
// -----------------------------------------------------------------------------
// fulladder
// Single-bit full adder cell used by the serial adder controller.
// Ports (order s, c, x, y, z):
//   s : output sum bit        x ^ y ^ z
//   c : output carry bit      majority(x, y, z)
//   x : input operand bit
//   y : input operand bit
//   z : input carry-in bit
// -----------------------------------------------------------------------------
module fulladder (
    output logic s,
    output logic c,
    input  logic x,
    input  logic y,
    input  logic z
);

    assign s = x ^ y ^ z;
    assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial adder: sequences one fulladder over a WIDTH-bit operand pair,
// LSB first, one bit per clock, with a start/busy/done handshake.
// Optional feature macro: SERIAL_ADD_SUB_EN (adds the 'sub' port; a - b).
//
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   start : request, sampled only in IDLE
//   a, b  : WIDTH-bit operands, captured at accept
//   cin   : carry-in, captured at accept (ignored when subtracting)
//   sub   : subtract select (only with SERIAL_ADD_SUB_EN)
//   busy  : high in RUN and DONE
//   done  : one-cycle pulse, result valid
//   sum   : registered WIDTH-bit result
//   cout  : registered carry out of the MSB (1 = no borrow when subtracting)
// -----------------------------------------------------------------------------
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_reg;
    state_t             state_next;
    logic               accept;
    logic               last_bit;

    logic [WIDTH-1:0]   a_sh_reg;
    logic [WIDTH-1:0]   b_sh_reg;
    logic               carry_reg;
    logic [CNT_W-1:0]   cnt_reg;
    // Holds the WIDTH-1 bits already produced; the final bit arrives on the
    // completing edge and is concatenated directly into sum.
    logic [WIDTH-2:0]   psum_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               cout_reg;

    logic               fa_s;
    logic               fa_c;
    logic [WIDTH-1:0]   shifted;

    logic               invert_b;
    logic               carry_load;
    logic [WIDTH-1:0]   b_load;

    // Subtraction is a + ~b + 1: invert b on load and force carry-in to 1.
`ifdef SERIAL_ADD_SUB_EN
    assign invert_b   = sub;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign invert_b   = 1'b0;
    assign carry_load = cin;
`endif

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_b_load
            assign b_load[gi] = b[gi] ^ invert_b;
        end
    endgenerate

    fulladder u_fa (
        .s (fa_s),
        .c (fa_c),
        .x (a_sh_reg[0]),
        .y (b_sh_reg[0]),
        .z (carry_reg)
    );

    // New sum bit enters at the MSB; after WIDTH bits this is the full result.
    assign shifted = {fa_s, psum_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        last_bit   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt_reg == LAST_CNT) begin
                    last_bit   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            psum_reg  <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
        end else if (accept) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b_load;
            carry_reg <= carry_load;
            cnt_reg   <= '0;
        end else if (state_reg == RUN) begin
            a_sh_reg  <= a_sh_reg >> 1;
            b_sh_reg  <= b_sh_reg >> 1;
            carry_reg <= fa_c;
            cnt_reg   <= cnt_reg + CNT_W'(1);
            psum_reg  <= shifted[WIDTH-1:1];
            if (last_bit) begin
                sum_reg  <= shifted;
                cout_reg <= fa_c;
            end
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Self-checking bench for serial_adder_ctrl (WIDTH = 8). Expected results come
// from plain integer arithmetic on the operands. Build with SERIAL_ADD_SUB_EN
// defined to exercise subtraction as well.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: unsigned add with carry-in, or a - b with cout = no borrow.
    function automatic logic [W:0] ref_result(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                              input logic rc, input logic rs);
        int unsigned r;
        if (rs) begin
            r = (int'(ra) - int'(rb)) & ((1 << W) - 1);
            return {(ra >= rb) ? 1'b1 : 1'b0, r[W-1:0]};
        end
        r = int'(ra) + int'(rb) + int'(rc);
        return r[W:0];
    endfunction

    // One operation from IDLE. glitch_at >= 0 pulses start with other operands
    // that many cycles into RUN (must be ignored).
    task automatic run_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic oc, input logic os, input int glitch_at);
        logic [W:0]   exp;
        logic [W-1:0] old_sum;
        logic         old_cout;
        logic         held;
        int           n;
        int           busy_cycles;
        int           extra_done;
        exp      = ref_result(oa, ob, oc, os);
        old_sum  = sum;
        old_cout = cout;
        held     = 1'b1;
        a = oa; b = ob; cin = oc; sub = os; start = 1'b1;
        tick();                                  // accept edge
        start = 1'b0;
        a = $urandom; b = $urandom; cin = $urandom; sub = $urandom;
        n = 0;
        busy_cycles = 0;
        while (!done && n < 40) begin
            if (busy) busy_cycles++;
            if (sum !== old_sum || cout !== old_cout) held = 1'b0;
            if (n == glitch_at) begin
                a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
            end
            tick();
            start = 1'b0;
            n++;
        end
        check({tag, " latency"}, n, W);          // done in cycle after edge E_W
        check({tag, " result held"}, held, 1'b1);
        check({tag, " busy at done"}, busy, 1'b1);
        busy_cycles++;
        check({tag, " sum"}, sum, exp[W-1:0]);
        check({tag, " cout"}, cout, exp[W]);
        $display("op %s a=%02h b=%02h cin=%0d sub=%0d -> sum=%02h cout=%0d (exp %02h/%0d) lat=%0d",
                 tag, oa, ob, oc, os, sum, cout, exp[W-1:0], exp[W], n);
        tick();
        check({tag, " busy cycles"}, busy_cycles, W + 1);
        check({tag, " idle after"}, {busy, done}, 2'b00);
        extra_done = 0;
        if (glitch_at >= 0) begin
            for (int i = 0; i < 12; i++) begin
                if (done || busy) extra_done++;
                tick();
            end
            check({tag, " no queued op"}, extra_done, 0);
            check({tag, " sum after"}, sum, exp[W-1:0]);
        end
    endtask

    initial begin
        int done_at [$];
        int cyc;
        int n;
        logic stable;
        logic [W:0] exp;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        tick(); tick();
        check("reset state", {busy, done, cout, sum}, '0);
        rst = 1'b0;
        tick();
        check("idle no start", {busy, done}, 2'b00);

        run_op("5a+3c", 8'h5A, 8'h3C, 1'b0, 1'b0, -1);
        run_op("ff+01", 8'hFF, 8'h01, 1'b0, 1'b0, -1);
        run_op("ff+00+c", 8'hFF, 8'h00, 1'b1, 1'b0, -1);
        run_op("ignore start", 8'h22, 8'h47, 1'b0, 1'b0, 2);

        // Reset 4 cycles into RUN aborts the operation.
        a = 8'h81; b = 8'h92; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", busy, 1'b0);
        check("abort sum", sum, 8'h00);
        check("abort cout", cout, 1'b0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) n++;
            tick();
        end
        check("abort no done", n, 0);
        run_op("10+20", 8'h10, 8'h20, 1'b0, 1'b0, -1);

        // start held high: back-to-back operations, one per W+2 cycles.
        exp = ref_result(8'h37, 8'hC4, 1'b1, 1'b0);
        a = 8'h37; b = 8'hC4; cin = 1'b1; sub = 1'b0; start = 1'b1;
        stable = 1'b1;
        for (cyc = 0; cyc < 30; cyc++) begin
            tick();
            if (done) done_at.push_back(cyc);
            if (done_at.size() > 0 && (sum !== exp[W-1:0] || cout !== exp[W])) stable = 1'b0;
        end
        start = 1'b0;
        check("held pulses", done_at.size(), 3);
        for (int i = 1; i < done_at.size(); i++)
            check("held spacing", done_at[i] - done_at[i-1], W + 2);
        check("held sum stable", stable, 1'b1);
        $display("held start: %0d done pulses", done_at.size());
        for (int i = 0; i < 12; i++) tick();

`ifdef SERIAL_ADD_SUB_EN
        run_op("10-01", 8'h10, 8'h01, 1'b0, 1'b1, -1);
        run_op("00-01", 8'h00, 8'h01, 1'b1, 1'b1, -1);
`endif

        for (int i = 0; i < 16; i++) begin
            logic rs;
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run_op("rand", 8'($urandom), 8'($urandom), 1'($urandom), rs, -1);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
